// File: rtl/sevenseg_pkg.sv
// Shared constants for BCD digits and active-low 7-segment patterns (bit order g..a).
package sevenseg_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;

    // Codes that can never be counted to still show a clean "0".
    localparam logic [SEG_W-1:0] SEG_DEFAULT = SEG_0;

    // Non-decimal nibbles are forced to zero so the count never leaves 0..9.
    function automatic logic [DIGIT_W-1:0] sanitize_digit(input logic [DIGIT_W-1:0] digit);
        return (digit > DIGIT_MAX) ? '0 : digit;
    endfunction

endpackage

// File: rtl/bcd_to_sevenseg.sv
// Combinational single-digit BCD to active-low 7-segment decoder.
module bcd_to_sevenseg
    import sevenseg_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [SEG_W-1:0]   o_seg_c
);

    always_comb begin
        o_seg_c = SEG_DEFAULT;
        case (i_digit)
            4'd0:    o_seg_c = SEG_0;
            4'd1:    o_seg_c = SEG_1;
            4'd2:    o_seg_c = SEG_2;
            4'd3:    o_seg_c = SEG_3;
            4'd4:    o_seg_c = SEG_4;
            4'd5:    o_seg_c = SEG_5;
            4'd6:    o_seg_c = SEG_6;
            4'd7:    o_seg_c = SEG_7;
            4'd8:    o_seg_c = SEG_8;
            4'd9:    o_seg_c = SEG_9;
            default: o_seg_c = SEG_DEFAULT;
        endcase
    end

endmodule

// File: rtl/bcd_display_counter.sv
// Multi-digit up/down BCD counter stepped by a clock divider, with registered
// 7-segment outputs and a limit carry pulse; wraps or saturates per WRAP.
module bcd_display_counter
    import sevenseg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned TICK_DIV   = 8388608,
    parameter int unsigned WRAP       = 1
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          up_down,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
    output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_count,
    output logic [SEG_W*NUM_DIGITS-1:0]   seg,
    output logic                          carry
);

    localparam int unsigned BCD_W   = DIGIT_W * NUM_DIGITS;
    localparam int unsigned SEGBUS_W = SEG_W * NUM_DIGITS;
    localparam int unsigned DIV_W   = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0]    r_div;
    logic [BCD_W-1:0]    r_bcd;
    logic [SEGBUS_W-1:0] r_seg;
    logic                r_carry;

    logic                w_tick;
    logic                w_all9;
    logic                w_all0;
    logic                w_at_limit;
    logic [BCD_W-1:0]    w_step;
    logic [BCD_W-1:0]    w_load_clean;
    logic [SEGBUS_W-1:0] w_seg_dec;

    assign w_tick     = enable && (r_div == DIV_LAST);
    assign w_all9     = (r_bcd == {NUM_DIGITS{DIGIT_MAX}});
    assign w_all0     = (r_bcd == '0);
    assign w_at_limit = up_down ? w_all9 : w_all0;

    // Per-digit ripple: a digit moves only when every lower digit is at its rollover value.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [DIGIT_W-1:0] w_cur;
        logic [DIGIT_W-1:0] w_next;
        logic               w_lo9;
        logic               w_lo0;

        assign w_cur = r_bcd[k*DIGIT_W +: DIGIT_W];

        always_comb begin
            w_lo9 = 1'b1;
            w_lo0 = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (r_bcd[j*DIGIT_W +: DIGIT_W] != DIGIT_MAX) w_lo9 = 1'b0;
                if (r_bcd[j*DIGIT_W +: DIGIT_W] != '0)        w_lo0 = 1'b0;
            end
        end

        always_comb begin
            w_next = w_cur;
            if (up_down) begin
                if (w_lo9) w_next = (w_cur >= DIGIT_MAX) ? '0 : w_cur + DIGIT_W'(1);
            end else begin
                if (w_lo0) w_next = (w_cur == '0) ? DIGIT_MAX : w_cur - DIGIT_W'(1);
            end
        end

        assign w_step[k*DIGIT_W +: DIGIT_W]       = w_next;
        assign w_load_clean[k*DIGIT_W +: DIGIT_W] = sanitize_digit(load_value[k*DIGIT_W +: DIGIT_W]);

        bcd_to_sevenseg u_dec (
            .i_digit (w_cur),
            .o_seg_c (w_seg_dec[k*SEG_W +: SEG_W])
        );
    end

    // Reset beats load, load beats tick; seg trails bcd_count by one clock.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_div   <= '0;
            r_bcd   <= '0;
            r_carry <= 1'b0;
            r_seg   <= {NUM_DIGITS{SEG_0}};
        end else begin
            r_seg   <= w_seg_dec;
            r_carry <= 1'b0;
            if (load) begin
                r_bcd <= w_load_clean;
                r_div <= '0;
            end else if (enable) begin
                r_div <= w_tick ? '0 : r_div + DIV_W'(1);
                if (w_tick) begin
                    r_carry <= w_at_limit;
                    if (!w_at_limit || (WRAP != 32'd0)) r_bcd <= w_step;
                end
            end
        end
    end

    assign bcd_count = r_bcd;
    assign seg       = r_seg;
    assign carry     = r_carry;

endmodule

// File: doc/bcd_display_counter.md
BCD_DISPLAY_COUNTER -- requirements
Module: bcd_display_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 2: number of cascaded decimal digits, legal range 1..8.
REQ-002 Parameter TICK_DIV, default 8388608: clock cycles per count step, legal range 2..2^24.
REQ-003 Parameter WRAP, default 1: 1 wraps at the limits, 0 saturates at the limits.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 enable  input  1  when high, the divider runs and count steps are allowed.
REQ-007 up_down  input  1  count direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_value  input  4*NUM_DIGITS  BCD value to load; digit 0 is in the LSBs.
REQ-010 bcd_count  output  4*NUM_DIGITS  registered BCD count.
REQ-011 seg  output  7*NUM_DIGITS  registered active-low 7-segment patterns, bit order g..a, digit 0 in the LSBs.
REQ-012 carry  output  1  one-cycle pulse on wrap or hit limit.

Function
REQ-013 Divider: counts 0..TICK_DIV-1 while enable=1, returns to 0 after TICK_DIV-1, and holds its value while enable=0.
REQ-014 tick is internal and is high in the cycle where divider==TICK_DIV-1 and enable=1.
REQ-015 On a tick edge, bcd_count steps by ±1 in decimal.
- Digit k changes only when all lower digits are 9 (up) or all lower digits are 0 (down).
- Each digit stays in 0..9.
REQ-016 Up at all-9s with WRAP=1: bcd_count goes to all-0s and carry=1 for the next cycle.
REQ-017 Down at all-0s with WRAP=1: bcd_count goes to all-9s and carry=1 for the next cycle.
REQ-018 Saturate mode (WRAP=0): at the limit, bcd_count holds, and carry=1 on each tick that would have crossed the limit.
REQ-019 carry is 0 in every other cycle.
REQ-020 load=1 has priority over tick in the same cycle.
- bcd_count takes load_value on that edge.
- The divider clears to 0.
- carry=0.
REQ-021 Any load_value digit above 9 loads as 0; valid digits load unchanged.
REQ-022 seg digit k is the decode of bcd_count digit k, one clock after bcd_count changes (latency 1).
- Patterns, 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Unreachable codes decode to the 0 pattern.
REQ-023 A change of up_down takes effect at the next tick, with no extra latency.
REQ-024 enable=0 freezes bcd_count, the divider and carry=0; load remains effective while enable=0.

Reset
REQ-025 reset=0 at a clock edge sets, on that edge:
- divider=0
- bcd_count=all-0s
- carry=0
- every seg digit=1000000
REQ-026 Reset overrides load and tick, and may assert mid-count; outputs hold their reset values while reset=0.
REQ-027 The first tick after reset release occurs TICK_DIV enabled cycles after release.

Structure
REQ-028 Shared package sevenseg_pkg holds:
- the ten segment pattern constants
- the blank/default pattern
- the BCD digit width constant (4)
- the segment width constant (7)
REQ-029 Sub-module bcd_to_sevenseg is a combinational 4-bit-to-7-bit decoder using sevenseg_pkg, instantiated NUM_DIGITS times via generate.
REQ-030 The per-digit increment/decrement ripple is a generate loop inside bcd_display_counter, with no further sub-modules.

Verification
Benches use TICK_DIV=4 and NUM_DIGITS=2 unless stated otherwise.
REQ-031 Reset, then enable=1, up_down=1 for 40 cycles -> bcd_count steps 00,01,...,09,10 at cycles 4,8,...,40; seg is 1000000_1000000 after reset; carry never pulses.
REQ-032 Load 99, up_down=1 -> the next tick gives 00 with carry=1 for exactly one cycle; with WRAP=0 it holds 99 and carry pulses on each tick.
REQ-033 Load 00, up_down=0 -> the next tick gives 99 with carry pulse; 10 followed by a down tick gives 09.
REQ-034 load=1 with load_value=0x3C coincident with a tick -> bcd_count=30, divider=0, carry=0; the next step comes 4 cycles later.
REQ-035 Assert reset mid-count at 57 -> the next edge gives bcd_count=00 and seg=0 patterns; enable=0 for 20 cycles -> the count is frozen.
REQ-036 NUM_DIGITS=4: load 0999, one up tick -> 1000; seg digit 3 = 1111001 one cycle after bcd_count updates.
